hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, meaning the number of consecutive MemBusy cycles after which MemTimeout is raised.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of the performance counters.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 ifid  input  IFID struct  current IF/ID buffer contents.
REQ-007 idex  input  IDEX struct  current ID/EX buffer contents.
REQ-008 exmem  input  EXMEM struct  current EX/MEM buffer contents.
REQ-009 memwb  input  MEMWB struct  current MEM/WB buffer contents.
REQ-010 BranchTaken  input  1  branch in EX resolved taken this cycle.
REQ-011 MemBusy  input  1  data memory not ready this cycle.
REQ-012 PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite  output  1 each  buffer/PC load enables.
REQ-013 IFIDFlush, IDEXFlush  output  1 each  clear the buffer to a bubble on the next edge.
REQ-014 ForwardA, ForwardB  output  2 each  operand source: 00 register file, 10 EXMEM.ALUResult, 01 MEMWB write-back data.
REQ-015 MemTimeout  output  1  sticky error flag.

Function
REQ-016 SHALL compute ForwardA combinationally as 10 when exmem.RegWrite and exmem.WriteRegister!=0 and it equals idex.ReadRegister1; else 01 on the same test with memwb; else 00.
- EX/MEM match has priority over MEM/WB.
REQ-017 SHALL compute ForwardB identically against idex.ReadRegister2.
REQ-018 SHALL detect load-use when idex.MemRead and idex.WriteRegister!=0 and it equals ifid.CurrInstr[19:15] or ifid.CurrInstr[24:20].
REQ-019 SHALL implement FSM states RUN, STALL and MEMWAIT.
REQ-020 Event priority SHALL be MemBusy > BranchTaken > load-use.
REQ-021 RUN with MemBusy SHALL drive all four enables to 0 and both flushes to 0, and SHALL go to MEMWAIT.
REQ-022 RUN with BranchTaken and no MemBusy SHALL drive IFIDFlush=1 and IDEXFlush=1 with all enables at 1, and SHALL stay in RUN.
REQ-023 RUN with load-use only SHALL drive PCWrite=0, IFIDWrite=0 and IDEXFlush=1, and SHALL go to STALL.
- STALL is a one-cycle bubble.
REQ-024 STALL SHALL mask load-use detection and return to RUN.
- MemBusy in STALL takes MEMWAIT.
- BranchTaken in STALL flushes as in RUN.
REQ-025 MEMWAIT SHALL hold all enables at 0 while MemBusy is high and count consecutive busy cycles.
- On MemBusy low, SHALL return to RUN with enables at 1 in that same cycle.
- Pending hazards are re-evaluated in that cycle.
REQ-026 MemTimeout SHALL set when the busy count reaches MEM_TIMEOUT.
- Stays set until reset.
- The count saturates at MEM_TIMEOUT.
REQ-027 With no event, outputs SHALL be: enables 1, flushes 0.

Reset
REQ-028 rst_n low at a rising edge SHALL set state RUN, clear the busy count and MemTimeout, and zero all counters.
REQ-029 While rst_n is low, SHALL drive enables 1, flushes 0 and Forward 00.
REQ-030 Reset mid-MEMWAIT or mid-STALL SHALL abandon that state with no residual stall.

Configuration
REQ-031 With HAZARD_PERF_CNT_EN defined, SHALL add outputs StallCount and FlushCount, each CNT_W bits.
- StallCount increments on each STALL or MEMWAIT cycle.
- FlushCount increments on each BranchTaken flush.
- Both wrap modulo 2^CNT_W.
REQ-032 Without HAZARD_PERF_CNT_EN, those ports and registers SHALL not exist.

Structure
REQ-033 The HazardState enum and the 2-bit forward-select constants (FWD_RF, FWD_EXMEM, FWD_MEMWB) SHALL live in the PipelineBufferRegisters package beside the buffer structs.
REQ-034 Forward selection SHALL be a sub-module forward_sel, instantiated twice: operand A and operand B.

Verification
REQ-035 idex.ReadRegister1=5; exmem.RegWrite=1, WriteRegister=5; memwb.WriteRegister=5 -> ForwardA=10.
- Same with exmem.WriteRegister=0 -> ForwardA=01.
REQ-036 idex.MemRead=1, WriteRegister=7; ifid.CurrInstr[24:20]=7 -> that cycle PCWrite=0, IFIDWrite=0, IDEXFlush=1; next cycle state STALL, all enables 1.
REQ-037 Load-use and BranchTaken in the same cycle -> IFIDFlush=1, IDEXFlush=1, PCWrite=1; state stays RUN.
REQ-038 MemBusy high 3 cycles -> enables 0 for exactly 3 cycles; MemTimeout stays 0.
- MemBusy high 16 cycles -> MemTimeout=1 after the 16th and holds after MemBusy drops.
REQ-039 rst_n low for one edge during MEMWAIT with MemBusy high -> next cycle state RUN, MemTimeout 0.
- Stall resumes only from a fresh MemBusy evaluation.
REQ-040 With HAZARD_PERF_CNT_EN: 2 load-use stalls plus a 4-cycle MemBusy plus 3 branch flushes -> StallCount=6, FlushCount=3.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// PipelineBufferRegisters: pipeline buffer structs, hazard FSM states and
// forward-select encodings shared by the hazard controller and its bench.
package PipelineBufferRegisters;

  typedef struct packed {
    logic [31:0] CurrInstr;
  } IFID;

  typedef struct packed {
    logic       MemRead;
    logic [4:0] WriteRegister;
    logic [4:0] ReadRegister1;
    logic [4:0] ReadRegister2;
  } IDEX;

  typedef struct packed {
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] ALUResult;
  } EXMEM;

  typedef struct packed {
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
  } MEMWB;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    MEMWAIT = 2'd2
  } HazardState;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // True when a writing stage targets a non-zero register equal to rReg.
  function automatic logic regMatch(input logic wr, input logic [4:0] wReg,
                                    input logic [4:0] rReg);
    return wr && (wReg != 5'd0) && (wReg == rReg);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline buffer snapshot in, stall/flush/forward controls out.
// Signal semantics: there is no valid/ready pairing here. Every input is a
// level sampled each cycle, and every control output answers the inputs of the
// same cycle. master = pipeline datapath, slave = hazard controller.
interface hazard_ctrl_if;
  import PipelineBufferRegisters::*;

  IFID        ifid;
  IDEX        idex;
  EXMEM       exmem;
  MEMWB       memwb;
  logic       BranchTaken;
  logic       MemBusy;

  logic       PCWrite;
  logic       IFIDWrite;
  logic       IDEXWrite;
  logic       EXMEMWrite;
  logic       IFIDFlush;
  logic       IDEXFlush;
  logic [1:0] ForwardA;
  logic [1:0] ForwardB;
  logic       MemTimeout;

  modport master (
    output ifid, idex, exmem, memwb, BranchTaken, MemBusy,
    input  PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush,
           ForwardA, ForwardB, MemTimeout
  );

  modport slave (
    input  ifid, idex, exmem, memwb, BranchTaken, MemBusy,
    output PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush,
           ForwardA, ForwardB, MemTimeout
  );

endinterface

// File: rtl/hazard_ctrl_forward_sel.sv
// forward_sel: picks one ALU operand source; the younger EX/MEM result wins
// over MEM/WB, register x0 is never forwarded.
module forward_sel
  import PipelineBufferRegisters::*;
(
  input  logic       exRegWrite,
  input  logic [4:0] exWriteReg,
  input  logic       memRegWrite,
  input  logic [4:0] memWriteReg,
  input  logic [4:0] readReg,
  output logic [1:0] fwdSel
);

  // Priority select of the operand source.
  always_comb begin
    fwdSel = FWD_RF;
    if (regMatch(exRegWrite, exWriteReg, readReg)) begin
      fwdSel = FWD_EXMEM;
    end else if (regMatch(memRegWrite, memWriteReg, readReg)) begin
      fwdSel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit -- forwarding, load-use stall, branch
// flush and data-memory wait with a sticky timeout flag.
// Optional feature macro: HAZARD_PERF_CNT_EN adds StallCount/FlushCount.
module hazard_ctrl
  import PipelineBufferRegisters::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus,
  output HazardState    stateDbg
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
`endif
);

  localparam int BCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [BCW-1:0] BUSY_MAX = BCW'(MEM_TIMEOUT);

  HazardState     state, nextState;
  logic [BCW-1:0] busyCnt, nextCnt;
  logic           memTimeoutQ;
  logic           loadUse, flushEvt;
  logic           pcW, ifidW, idexW, exmemW, ifidF, idexF;
  logic [1:0]     fwdA, fwdB;

  // Instruction fields and data buses that only pass through this block.
  logic unusedBits;
  assign unusedBits = ^{bus.ifid.CurrInstr[31:25], bus.ifid.CurrInstr[14:0],
                        bus.exmem.ALUResult, bus.memwb.WriteData};

  forward_sel fwdSelA (
    .exRegWrite (bus.exmem.RegWrite),
    .exWriteReg (bus.exmem.WriteRegister),
    .memRegWrite(bus.memwb.RegWrite),
    .memWriteReg(bus.memwb.WriteRegister),
    .readReg    (bus.idex.ReadRegister1),
    .fwdSel     (fwdA)
  );

  forward_sel fwdSelB (
    .exRegWrite (bus.exmem.RegWrite),
    .exWriteReg (bus.exmem.WriteRegister),
    .memRegWrite(bus.memwb.RegWrite),
    .memWriteReg(bus.memwb.WriteRegister),
    .readReg    (bus.idex.ReadRegister2),
    .fwdSel     (fwdB)
  );

  // A load in EX whose destination feeds either source of the decoding instr.
  assign loadUse = bus.idex.MemRead && (bus.idex.WriteRegister != 5'd0) &&
                   ((bus.idex.WriteRegister == bus.ifid.CurrInstr[19:15]) ||
                    (bus.idex.WriteRegister == bus.ifid.CurrInstr[24:20]));

  // Control decode: MemBusy beats BranchTaken beats load-use; a MEMWAIT exit
  // cycle is decoded exactly like RUN so hazards waiting behind it are seen.
  always_comb begin
    pcW       = 1'b1;
    ifidW     = 1'b1;
    idexW     = 1'b1;
    exmemW    = 1'b1;
    ifidF     = 1'b0;
    idexF     = 1'b0;
    flushEvt  = 1'b0;
    nextState = RUN;
    nextCnt   = '0;
    if (rst_n) begin
      if (bus.MemBusy) begin
        pcW       = 1'b0;
        ifidW     = 1'b0;
        idexW     = 1'b0;
        exmemW    = 1'b0;
        nextState = MEMWAIT;
        if (state != MEMWAIT) begin
          nextCnt = BCW'(1);
        end else if (busyCnt == BUSY_MAX) begin
          nextCnt = busyCnt;
        end else begin
          nextCnt = busyCnt + BCW'(1);
        end
      end else if (bus.BranchTaken) begin
        ifidF    = 1'b1;
        idexF    = 1'b1;
        flushEvt = 1'b1;
      end else if (loadUse && (state != STALL)) begin
        pcW       = 1'b0;
        ifidW     = 1'b0;
        idexF     = 1'b1;
        nextState = STALL;
      end
    end
  end

  // State, consecutive-busy count and sticky timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      busyCnt     <= '0;
      memTimeoutQ <= 1'b0;
    end else begin
      state   <= nextState;
      busyCnt <= nextCnt;
      if (bus.MemBusy && (nextCnt == BUSY_MAX)) begin
        memTimeoutQ <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Free-running counters of stalled cycles and branch flushes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (state != RUN) begin
        StallCount <= StallCount + CNT_W'(1);
      end
      if (flushEvt) begin
        FlushCount <= FlushCount + CNT_W'(1);
      end
    end
  end
`else
  localparam int unusedCntW = CNT_W;
`endif

  assign bus.PCWrite    = pcW;
  assign bus.IFIDWrite  = ifidW;
  assign bus.IDEXWrite  = idexW;
  assign bus.EXMEMWrite = exmemW;
  assign bus.IFIDFlush  = ifidF;
  assign bus.IDEXFlush  = idexF;
  assign bus.ForwardA   = rst_n ? fwdA : FWD_RF;
  assign bus.ForwardB   = rst_n ? fwdB : FWD_RF;
  assign bus.MemTimeout = memTimeoutQ;
  assign stateDbg       = state;

endmodule
